// File: rtl/binary_to_eseg.sv
// rtl/binary_to_eseg.sv - prescaled free-running digit counter with eight-segment display code
//
// Purpose:
//   Counts 0..MODULUS-1 on a tick from a DIV-cycle prescaler and shows the
//   current digit as a registered {dp,g,f,e,d,c,b,a} segment code. The decimal
//   point toggles on every wrap, so it shows the parity of the roll-over count.
//
// Parameters:
//   DIV      clock cycles per count step, 1..65535 (1 = advance every clock)
//   MODULUS  digit values before wrap, 2..16 (10 = decimal, 16 = hex)
//
// Ports:
//   value  output [7:0]  registered segment code {dp,g,f,e,d,c,b,a}
//   clk    input         system clock, rising edge
//   reset  input         asynchronous active-low reset
//
// Optional build macro:
//   ESEG_ACTIVE_LOW_EN  drive the bitwise complement of every code, for
//                       common-anode displays (reset code becomes 8'hC0)

module binary_to_eseg #(
  parameter int unsigned DIV     = 1,
  parameter int unsigned MODULUS = 16
) (
  output logic [7:0] value,
  input  logic       clk,
  input  logic       reset
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef ESEG_ACTIVE_LOW_EN
  localparam logic [7:0] POLARITY = 8'hFF;
`else
  localparam logic [7:0] POLARITY = 8'h00;
`endif

  localparam logic [7:0] RESET_CODE = 8'h3F ^ POLARITY;

  logic [PW-1:0] pcnt;
  logic [3:0]    digit;
  logic          dp;

  logic          tick;
  logic [PW-1:0] pcnt_next;
  logic [3:0]    digit_next;
  logic          dp_next;

  // Segment pattern gfedcba for one digit; digits outside the modulus can
  // only appear through a fault, so they show a dash instead of a hex glyph.
  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] s;
    s = 7'h40;
    if ({1'b0, d} < 5'(MODULUS)) begin
      case (d)
        4'h0: s = 7'h3F;
        4'h1: s = 7'h06;
        4'h2: s = 7'h5B;
        4'h3: s = 7'h4F;
        4'h4: s = 7'h66;
        4'h5: s = 7'h6D;
        4'h6: s = 7'h7D;
        4'h7: s = 7'h07;
        4'h8: s = 7'h7F;
        4'h9: s = 7'h6F;
        4'hA: s = 7'h77;
        4'hB: s = 7'h7C;
        4'hC: s = 7'h39;
        4'hD: s = 7'h5E;
        4'hE: s = 7'h79;
        4'hF: s = 7'h71;
        default: s = 7'h40;
      endcase
    end
    return s;
  endfunction

  // With DIV=1 the compare is against zero on a 1-bit counter that never
  // leaves zero, so tick stays high and the digit advances every clock.
  assign tick = (pcnt == PW'(DIV - 1));

  always_comb begin
    pcnt_next  = pcnt + PW'(1);
    digit_next = digit;
    dp_next    = dp;
    if (tick) begin
      pcnt_next = '0;
      if (digit == 4'(MODULUS - 1)) begin
        digit_next = 4'd0;
        dp_next    = ~dp;
      end else begin
        digit_next = digit + 4'd1;
      end
    end
  end

  // value is computed from the next-state digit/dp so the display never lags
  // the count state by a cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt  <= '0;
      digit <= 4'd0;
      dp    <= 1'b0;
      value <= RESET_CODE;
    end else begin
      pcnt  <= pcnt_next;
      digit <= digit_next;
      dp    <= dp_next;
      value <= {dp_next, seg(digit_next)} ^ POLARITY;
    end
  end

endmodule

// File: tb/tb_binary_to_eseg.sv
// tb/tb_binary_to_eseg.sv - scoreboard bench for binary_to_eseg (hex, prescaled, decimal)

module tb_binary_to_eseg;

`ifdef ESEG_ACTIVE_LOW_EN
  localparam logic [7:0] INV = 8'hFF;
`else
  localparam logic [7:0] INV = 8'h00;
`endif

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic       clk;
  logic       reset;
  logic [7:0] val_hex;
  logic [7:0] val_pre;
  logic [7:0] val_dec;

  logic [7:0] q_hex [$];
  logic [7:0] q_pre [$];
  logic [7:0] q_dec [$];

  int compared;
  int mismatched;

  binary_to_eseg #(.DIV(1), .MODULUS(16)) u_hex (.value(val_hex), .clk(clk), .reset(reset));
  binary_to_eseg #(.DIV(4), .MODULUS(16)) u_pre (.value(val_pre), .clk(clk), .reset(reset));
  binary_to_eseg #(.DIV(1), .MODULUS(10)) u_dec (.value(val_dec), .clk(clk), .reset(reset));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected code after cnt count steps for a given modulus.
  function automatic logic [7:0] exp_code(input int cnt, input int modu);
    int d;
    logic p;
    d = cnt % modu;
    p = ((cnt / modu) % 2) == 1;
    return {p, SEG_TBL[d]} ^ INV;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_all(input logic [7:0] eh, input logic [7:0] ep, input logic [7:0] ed);
    q_hex.push_back(eh);
    q_pre.push_back(ep);
    q_dec.push_back(ed);
  endtask

  // Monitor: value is sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (q_hex.size() > 0) check("hex", val_hex, q_hex.pop_front());
    if (q_pre.size() > 0) check("prescale", val_pre, q_pre.pop_front());
    if (q_dec.size() > 0) check("decimal", val_dec, q_dec.pop_front());
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;

    // Held in reset for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      push_all(8'h3F ^ INV, 8'h3F ^ INV, 8'h3F ^ INV);
    end

    // Release after an edge; the next edge is the first with reset high.
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      push_all(exp_code(k, 16), exp_code(k / 4, 16), exp_code(k, 10));
    end

    // Asynchronous reset mid-cycle must clear value before the next edge.
    @(posedge clk);
    #3;
    reset = 1'b0;
    push_all(8'h3F ^ INV, 8'h3F ^ INV, 8'h3F ^ INV);
    @(posedge clk);
    #1;
    push_all(8'h3F ^ INV, 8'h3F ^ INV, 8'h3F ^ INV);

    repeat (3) @(negedge clk);
    #1;
    compared++;
    if (q_hex.size() + q_pre.size() + q_dec.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, expected 0", q_hex.size() + q_pre.size() + q_dec.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
